// File: rtl/xup_debounce_toggle_gen.sv
// xup_debounce_toggle_gen
// -----------------------------------------------------------------------------
// Front end for the vector T flip-flop. Each raw pushbutton bit is passed
// through a 2-flop synchronizer and then debounced. A bit's debounced level
// changes only after STABLE consecutive identical samples, with one sample
// taken every TICK_DIV clk cycles. Each debounced rise (0 -> 1) produces a
// single-cycle pulse on t, so one clean press toggles one downstream bit once.
// en is high in exactly the cycles where t is nonzero.
//
// Optional build macro: XUP_TOGGLE_AUTOREPEAT_EN
//   When defined, a button that stays pressed issues another pulse every
//   REPEAT ticks, until its debounced level falls.
//   When undefined, each debounced press produces exactly one pulse.
//
// Parameters:
//   SIZE     vector width (matches downstream T-FF)
//   DELAY    output delay in ns for timing models; this RTL uses zero delay
//   TICK_DIV clk cycles per debounce sample tick (>= 1)
//   STABLE   identical samples needed to change db (>= 2)
//   REPEAT   ticks between auto-repeat pulses (>= 1, optional feature only)
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high; has priority over everything
//   btn    in   [SIZE] raw asynchronous button levels, active-high
//   t      out  [SIZE] registered toggle pulses
//   en     out  registered, high when t != 0
//   db     out  [SIZE] registered debounced level
// -----------------------------------------------------------------------------
module xup_debounce_toggle_gen #(
    parameter int SIZE     = 8,
    parameter int DELAY    = 3,
    parameter int TICK_DIV = 1000,
    parameter int STABLE   = 4,
    parameter int REPEAT   = 50
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] btn,
    output logic [SIZE-1:0] t,
    output logic            en,
    output logic [SIZE-1:0] db
);

    // Elaboration-time parameter sanity check; never part of the hardware.
    if (TICK_DIV < 1 || STABLE < 2 || REPEAT < 1 || DELAY < 0) begin : g_bad_params
        $error("xup_debounce_toggle_gen: illegal parameter combination");
    end

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0]     pre_cnt;
    logic              tick;
    logic [SIZE-1:0]   sa;          // first synchronizer stage
    logic [SIZE-1:0]   sb;          // second synchronizer stage
    logic [STABLE-1:0] hist       [SIZE];
    logic [STABLE-1:0] hist_shift [SIZE];
    logic [SIZE-1:0]   db_next;
    logic [SIZE-1:0]   db_d;        // db one cycle late, for rise detection
    logic [SIZE-1:0]   rep_fire;
    logic [SIZE-1:0]   t_next;

    // Prescaler: tick is high for the single cycle where the count is at
    // its top value. With TICK_DIV = 1 the counter stays at 0 and tick is
    // high every cycle.
    assign tick = (pre_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // History after this tick's shift. db is updated from this value, so
    // db changes on the same edge that stores the final sample of a run.
    always_comb begin
        db_next = db;
        for (int i = 0; i < SIZE; i++) begin
            hist_shift[i] = {hist[i][STABLE-2:0], sb[i]};
            if (tick) begin
                if (&hist_shift[i]) begin
                    db_next[i] = 1'b1;
                end else if (~|hist_shift[i]) begin
                    db_next[i] = 1'b0;
                end
            end
        end
    end

    // A pulse is issued the cycle after db rises, or when an auto-repeat fires.
    assign t_next = (db & ~db_d) | rep_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            sa   <= '0;
            sb   <= '0;
            db   <= '0;
            db_d <= '0;
            t    <= '0;
            en   <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                hist[i] <= '0;
            end
        end else begin
            sa   <= btn;
            sb   <= sa;
            db   <= db_next;
            db_d <= db;
            t    <= t_next;
            en   <= |t_next;
            if (tick) begin
                for (int i = 0; i < SIZE; i++) begin
                    hist[i] <= hist_shift[i];
                end
            end
        end
    end

`ifdef XUP_TOGGLE_AUTOREPEAT_EN
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    logic [RW-1:0] rep_cnt [SIZE];

    // The counter is held at 0 while db is low. It is also held at 0 on the
    // edge where db rises, because db is still 0 on that edge, and on the
    // edge where db falls. While db stays high, the counter counts ticks.
    // Reaching REPEAT-1 arms a pulse for the next tick, so repeats are
    // REPEAT ticks apart. rep_fire lasts one cycle and then feeds t_next.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_fire <= '0;
            for (int i = 0; i < SIZE; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            rep_fire <= '0;
            for (int i = 0; i < SIZE; i++) begin
                if (!db[i] || !db_next[i]) begin
                    rep_cnt[i] <= '0;
                end else if (tick) begin
                    if (rep_cnt[i] == RW'(REPEAT - 1)) begin
                        rep_cnt[i]  <= '0;
                        rep_fire[i] <= 1'b1;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_xup_debounce_toggle_gen.sv
// Testbench for xup_debounce_toggle_gen (TICK_DIV=4, STABLE=3, SIZE=8, REPEAT=5).
// Directed vectors. A negedge monitor records every cycle where t or en is
// nonzero, packed as {en, t}. These records are compared with a queue of
// expected pulses that the bench builds by hand.
module tb_xup_debounce_toggle_gen;

    localparam int SIZE     = 8;
    localparam int TICK_DIV = 4;
    localparam int STABLE   = 3;
    localparam int REPEAT   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [SIZE-1:0] btn;
    logic [SIZE-1:0] t;
    logic            en;
    logic [SIZE-1:0] db;

    xup_debounce_toggle_gen #(
        .SIZE     (SIZE),
        .DELAY    (3),
        .TICK_DIV (TICK_DIV),
        .STABLE   (STABLE),
        .REPEAT   (REPEAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .t     (t),
        .en    (en),
        .db    (db)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    logic [SIZE:0]   exp_q[$];
    logic [SIZE:0]   obs_q[$];
    int              obs_cyc[$];
    logic            mon_on = 1'b0;
    logic [SIZE-1:0] db_seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            db_seen = db_seen | db;
            if (t != '0 || en != 1'b0) begin
                obs_q.push_back({en, t});
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic drain(input string tag);
        check_val({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check_val(tag, obs_q.pop_front(), exp_q.pop_front());
        end
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge. Waits until db[b] reaches v, for at most bound cycles.
    task automatic wait_db(input int b, input logic v, input int bound, output int n);
        n = 0;
        while (db[b] !== v && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (db[b] !== v) check_val("wait_db_timeout", n, bound + 1);
    endtask

    task automatic release_all(input string tag);
        int n;
        btn = '0;
        wait_db(0, 1'b0, 40, n);
        wait_db(7, 1'b0, 40, n);
        idle(5);
        check_val({tag, "_db_low"}, db, 0);
        drain(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, c0, lat, db_cyc;
        reset   = 1'b1;
        btn     = '0;
        db_seen = '0;

        // Reset held for 3 cycles: every output must be 0.
        repeat (3) begin
            @(negedge clk);
            check_val("rst_t", t, 0);
            check_val("rst_en", en, 0);
            check_val("rst_db", db, 0);
        end
        reset  = 1'b0;
        mon_on = 1'b1;
        idle(20);
        check_val("idle_db", db, 0);
        drain("idle");

        // One press: db rises 11..15 cycles after btn, and one pulse of 0x01
        // follows one cycle later.
        btn = 8'h01;
        c0  = cyc;
        wait_db(0, 1'b1, 30, n);
        lat    = cyc - c0;
        db_cyc = cyc;
        check_val("press_db_latency_in_range", (lat >= 11 && lat <= 15), 1);
        idle(40 - lat);
        check_val("press_db", db, 8'h01);
        check_val("press_pulse_offset", (obs_cyc.size() > 0) ? obs_cyc[0] - db_cyc : -1, 1);
        exp_q.push_back({1'b1, 8'h01});
        drain("press");
        release_all("press_release");

        // Glitch: btn[3] is high for 6 cycles, which is fewer than 3 ticks.
        db_seen = '0;
        btn = 8'h08;
        idle(6);
        btn = '0;
        idle(30);
        check_val("glitch_db_seen", db_seen, 0);
        drain("glitch");

        // Simultaneous rise of bits 0 and 2 gives one combined pulse.
        btn = 8'h05;
        wait_db(0, 1'b1, 30, n);
        idle(10);
        check_val("simul_db", db, 8'h05);
        exp_q.push_back({1'b1, 8'h05});
        drain("simul");
        release_all("simul_release");

        // Reset arrives on the edge where the pulse would have fired. The
        // pulse is not replayed. After release, the prescaler restarts at 0,
        // so ticks fall on posedges 4, 8 and 12 and db rises on posedge 12.
        btn = 8'h01;
        wait_db(0, 1'b1, 30, n);
        reset = 1'b1;
        @(negedge clk);
        check_val("rstmid_t", t, 0);
        check_val("rstmid_en", en, 0);
        check_val("rstmid_db", db, 0);
        reset = 1'b0;
        c0 = cyc;
        wait_db(0, 1'b1, 40, n);
        check_val("rstmid_relatch_latency", cyc - c0, 12);
        idle(10);
        exp_q.push_back({1'b1, 8'h01});
        drain("rstmid");
        release_all("rstmid_release");

`ifdef XUP_TOGGLE_AUTOREPEAT_EN
        // Held for 120 cycles: the first pulse at debounce, then one every
        // 20 cycles (5 ticks). This gives 6 pulses before db[7] falls.
        btn = 8'h80;
        idle(120);
        btn = '0;
        wait_db(7, 1'b0, 40, n);
        idle(5);
        for (int j = 1; j < obs_cyc.size(); j++) begin
            check_val("autorep_gap", obs_cyc[j] - obs_cyc[j-1], 20);
        end
        for (int j = 0; j < 6; j++) exp_q.push_back({1'b1, 8'h80});
        drain("autorep");
`endif

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
